// File: rtl/peak_ctrl_pkg.sv
// Shared constants and state type for the centroid peak-detector frame sequencer.
package peak_ctrl_pkg;

   localparam int DEF_DATAWIDTH = 12;
   localparam int DEF_FRAC_BITS = 4;
   localparam int DEF_SUM_W     = 30;

   // Each sum arrives as three 10-bit words; the integer part of the index is 10 bits.
   localparam int WORD_W    = 10;
   localparam int INT_BITS  = 10;
   localparam int NUM_WORDS = 6;
   localparam int WCNT_W    = 3;

   // Serial slot order of the six peak_info words.
   localparam logic [WCNT_W-1:0] SLOT_M_LO  = 3'd0;
   localparam logic [WCNT_W-1:0] SLOT_M_MID = 3'd1;
   localparam logic [WCNT_W-1:0] SLOT_M_HI  = 3'd2;
   localparam logic [WCNT_W-1:0] SLOT_N_LO  = 3'd3;
   localparam logic [WCNT_W-1:0] SLOT_N_MID = 3'd4;
   localparam logic [WCNT_W-1:0] SLOT_N_HI  = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_WAIT_HI,
      ST_WAIT_LO,
      ST_COLLECT,
      ST_DIVIDE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/peak_frame_ctrl_if.sv
// Detector-side and host-side signals of the frame sequencer, bundled as one bus.
interface peak_frame_ctrl_if
   import peak_ctrl_pkg::*;
#(
   parameter int DATAWIDTH = DEF_DATAWIDTH,
   parameter int FRAC_BITS = DEF_FRAC_BITS,
   parameter int SUM_W     = DEF_SUM_W
);
   logic                         frame_start;
   logic                         vald_data;
   logic                         pdet_en_cfg;
   logic [DATAWIDTH-1:0]         peak_info;
   logic                         peak_valid;
   logic                         start_act;
   logic                         pdet_en;
   logic                         busy;
   logic                         result_valid;
   logic [INT_BITS+FRAC_BITS-1:0] centroid;
   logic [SUM_W-1:0]             sum_n;
   logic                         no_peak;
   logic                         sat;
   logic                         seq_err;
   logic                         frame_drop;

   // Side that supplies frames and detector words and consumes the results.
   modport master (
      output frame_start, vald_data, pdet_en_cfg, peak_info, peak_valid,
      input  start_act, pdet_en, busy, result_valid, centroid, sum_n,
             no_peak, sat, seq_err, frame_drop
   );

   // The sequencer itself.
   modport slave (
      input  frame_start, vald_data, pdet_en_cfg, peak_info, peak_valid,
      output start_act, pdet_en, busy, result_valid, centroid, sum_n,
             no_peak, sat, seq_err, frame_drop
   );

endinterface

// File: rtl/peak_centroid_div.sv
// Restoring divider: one quotient bit per cycle, MSB first, NUM_W cycles per division.
// quotient is the combinational result of the current step; it is the final
// quotient in the cycle where done is high.
module peak_centroid_div #(
   parameter int NUM_W = 34,
   parameter int DEN_W = 30
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [NUM_W-1:0] num,
   input  logic [DEN_W-1:0] den,
   output logic [NUM_W-1:0] quotient,
   output logic             done
);
   localparam int CNT_W = $clog2(NUM_W + 1);

   logic [NUM_W-1:0] q_reg;
   logic [DEN_W-1:0] rem_reg;
   logic [DEN_W-1:0] den_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [DEN_W:0]   trial;
   logic [DEN_W-1:0] rem_next;
   logic             q_bit;

   // One restoring step: shift in the next numerator bit, subtract if it fits.
   // The remainder stays below den, so the difference always fits in DEN_W bits.
   always_comb begin
      trial    = {rem_reg, q_reg[NUM_W-1]};
      q_bit    = (trial >= {1'b0, den_reg});
      rem_next = q_bit ? (trial[DEN_W-1:0] - den_reg) : trial[DEN_W-1:0];
      quotient = {q_reg[NUM_W-2:0], q_bit};
      done     = (cnt_reg == CNT_W'(1));
   end

   // Load operands on start, then iterate until the step counter runs out.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         q_reg   <= '0;
         rem_reg <= '0;
         den_reg <= '0;
         cnt_reg <= '0;
      end else if (start) begin
         q_reg   <= num;
         rem_reg <= '0;
         den_reg <= den;
         cnt_reg <= CNT_W'(NUM_W);
      end else if (cnt_reg != '0) begin
         q_reg   <= quotient;
         rem_reg <= rem_next;
         cnt_reg <= cnt_reg - CNT_W'(1);
      end
   end

endmodule

// File: rtl/peak_frame_ctrl.sv
// Per-frame sequencer for the centroid peak detector: arms the detector, collects
// the six serialized sum words and divides sum_m by sum_n into a 10.F index.
module peak_frame_ctrl
   import peak_ctrl_pkg::*;
#(
   parameter int DATAWIDTH = DEF_DATAWIDTH,
   parameter int FRAC_BITS = DEF_FRAC_BITS,
   parameter int SUM_W     = DEF_SUM_W
) (
   input  logic clk,
   input  logic reset_n,
   peak_frame_ctrl_if.slave bus
);
   localparam int NUM_W  = SUM_W + FRAC_BITS;
   localparam int CENT_W = INT_BITS + FRAC_BITS;

   state_t                      state_reg, state_next;
   logic [WCNT_W-1:0]           wcnt_reg, wcnt_next;
   logic [NUM_WORDS*WORD_W-1:0] slots_flat;
   logic                        word_take;
   logic                        seq_err_next;
   logic                        div_start;
   logic                        div_done;
   logic [NUM_W-1:0]            div_quotient;
   logic                        quot_ovf;
   logic [WORD_W-1:0]           n_hi_word;
   logic [SUM_W-1:0]            sum_m_full;
   logic [SUM_W-1:0]            sum_n_full;

   logic                        pdet_en_reg;
   logic                        seq_err_reg;
   logic                        frame_drop_reg;
   logic                        no_peak_reg;
   logic                        sat_reg;
   logic [CENT_W-1:0]           centroid_reg;
   logic [SUM_W-1:0]            sum_n_reg;

   logic                        unused_pinfo_hi;
   assign unused_pinfo_hi = ^bus.peak_info[DATAWIDTH-1:WORD_W];

   assign word_take = (state_reg == ST_COLLECT) && bus.peak_valid && !bus.vald_data;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_WORDS; gi++) begin : g_slot
         logic [WORD_W-1:0] word_reg;
         // Capture the word addressed by the running word counter.
         always_ff @(posedge clk) begin
            if (!reset_n)
               word_reg <= '0;
            else if (word_take && (wcnt_reg == WCNT_W'(gi)))
               word_reg <= bus.peak_info[WORD_W-1:0];
         end
         assign slots_flat[gi*WORD_W +: WORD_W] = word_reg;
      end
   endgenerate

   // While the last word is on the bus it has not been stored yet, so take it directly.
   assign n_hi_word  = (state_reg == ST_COLLECT) ? bus.peak_info[WORD_W-1:0]
                                                 : slots_flat[SLOT_N_HI*WORD_W +: WORD_W];
   assign sum_m_full = SUM_W'({slots_flat[SLOT_M_HI*WORD_W +: WORD_W],
                               slots_flat[SLOT_M_MID*WORD_W +: WORD_W],
                               slots_flat[SLOT_M_LO*WORD_W +: WORD_W]});
   assign sum_n_full = SUM_W'({n_hi_word,
                               slots_flat[SLOT_N_MID*WORD_W +: WORD_W],
                               slots_flat[SLOT_N_LO*WORD_W +: WORD_W]});

   peak_centroid_div #(
      .NUM_W (NUM_W),
      .DEN_W (SUM_W)
   ) u_div (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (div_start),
      .num      ({sum_m_full, {FRAC_BITS{1'b0}}}),
      .den      (sum_n_full),
      .quotient (div_quotient),
      .done     (div_done)
   );

   assign quot_ovf = |div_quotient[NUM_W-1:CENT_W];

   // Frame sequencing: next state, word counter, divider start and protocol errors.
   always_comb begin
      state_next   = state_reg;
      wcnt_next    = wcnt_reg;
      seq_err_next = 1'b0;
      div_start    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (bus.frame_start && bus.pdet_en_cfg)
               state_next = ST_ARM;
         end
         ST_ARM: begin
            if (bus.vald_data) begin
               seq_err_next = 1'b1;
               state_next   = ST_IDLE;
            end else begin
               state_next = ST_WAIT_HI;
            end
         end
         ST_WAIT_HI: begin
            if (bus.vald_data)
               state_next = ST_WAIT_LO;
         end
         ST_WAIT_LO: begin
            if (!bus.vald_data) begin
               state_next = ST_COLLECT;
               wcnt_next  = '0;
            end
         end
         ST_COLLECT: begin
            if (bus.vald_data) begin
               seq_err_next = 1'b1;
               state_next   = ST_IDLE;
            end else if (bus.peak_valid) begin
               wcnt_next = wcnt_reg + WCNT_W'(1);
               if (wcnt_reg == WCNT_W'(NUM_WORDS - 1)) begin
                  if (sum_n_full == '0) begin
                     state_next = ST_DONE;
                  end else begin
                     state_next = ST_DIVIDE;
                     div_start  = 1'b1;
                  end
               end
            end else if (wcnt_reg != '0) begin
               // Word burst broke off before all six words arrived.
               seq_err_next = 1'b1;
               state_next   = ST_IDLE;
            end
         end
         ST_DIVIDE: begin
            if (div_done)
               state_next = ST_DONE;
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State, word counter, detector enable and one-cycle status pulses.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg      <= ST_IDLE;
         wcnt_reg       <= '0;
         pdet_en_reg    <= 1'b0;
         seq_err_reg    <= 1'b0;
         frame_drop_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         wcnt_reg       <= wcnt_next;
         pdet_en_reg    <= (state_next != ST_IDLE);
         seq_err_reg    <= seq_err_next;
         frame_drop_reg <= bus.frame_start && (state_reg != ST_IDLE);
      end
   end

   // Result registers, loaded on entry to DONE and held until the next one.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         centroid_reg <= '0;
         sum_n_reg    <= '0;
         no_peak_reg  <= 1'b0;
         sat_reg      <= 1'b0;
      end else if ((state_reg == ST_COLLECT) && (state_next == ST_DONE)) begin
         centroid_reg <= '0;
         sum_n_reg    <= sum_n_full;
         no_peak_reg  <= 1'b1;
         sat_reg      <= 1'b0;
      end else if ((state_reg == ST_DIVIDE) && div_done) begin
         centroid_reg <= quot_ovf ? '1 : div_quotient[CENT_W-1:0];
         sum_n_reg    <= sum_n_full;
         no_peak_reg  <= 1'b0;
         sat_reg      <= quot_ovf;
      end
   end

   assign bus.start_act    = (state_reg == ST_ARM);
   assign bus.busy         = (state_reg != ST_IDLE);
   assign bus.result_valid = (state_reg == ST_DONE);
   assign bus.pdet_en      = pdet_en_reg;
   assign bus.seq_err      = seq_err_reg;
   assign bus.frame_drop   = frame_drop_reg;
   assign bus.centroid     = centroid_reg;
   assign bus.sum_n        = sum_n_reg;
   assign bus.no_peak      = no_peak_reg;
   assign bus.sat          = sat_reg;

endmodule
